// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron pipeline stages.
// Holds the synapse accumulator FSM state encoding, the accumulator width
// rule and an unsigned saturating clamp reused by later neuron stages.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  // Wide enough that NUM_SYNAPSES worst-case weights of either sign cannot
  // overflow: one bit per doubling of the synapse count plus a guard bit.
  function automatic int acc_width(input int weight_width, input int num_synapses);
    return weight_width + $clog2(num_synapses) + 1;
  endfunction

  // Saturate a signed value into [0, 2^out_width-1]; caller truncates the
  // 64-bit result to out_width bits.
  function automatic logic [63:0] clamp_unsigned(input logic signed [63:0] value,
                                                 input int out_width);
    logic [63:0] max_val;
    max_val = (64'd1 << out_width) - 64'd1;
    if (value < 64'sd0) begin
      return 64'd0;
    end else if ($unsigned(value) > max_val) begin
      return max_val;
    end else begin
      return $unsigned(value);
    end
  endfunction

endpackage

// File: rtl/synapse_accumulator_if.sv
// Frame, weight-write and result signals of the synapse accumulator.
// master: spike/weight source (drives spike_in*, weight_*), slave: accumulator.
// Frame handshake is valid/ready; result is a one-cycle strobe, no backpressure.
interface synapse_accumulator_if #(
  parameter int NUM_SYNAPSES             = 8,
  parameter int WEIGHT_WIDTH             = 8,
  parameter int MEMBRANE_POTENTIAL_WIDTH = 8
);
  localparam int ADDR_WIDTH = $clog2(NUM_SYNAPSES);

  logic [NUM_SYNAPSES-1:0]             spike_in;
  logic                                spike_in_valid;
  logic                                spike_in_ready;
  logic                                weight_we;
  logic [ADDR_WIDTH-1:0]               weight_addr;
  logic signed [WEIGHT_WIDTH-1:0]      weight_wdata;
  logic [MEMBRANE_POTENTIAL_WIDTH-1:0] synaptic_input;
  logic                                synaptic_valid;
  logic                                busy;

  modport master (
    output spike_in, spike_in_valid, weight_we, weight_addr, weight_wdata,
    input  spike_in_ready, synaptic_input, synaptic_valid, busy
  );

  modport slave (
    input  spike_in, spike_in_valid, weight_we, weight_addr, weight_wdata,
    output spike_in_ready, synaptic_input, synaptic_valid, busy
  );
endinterface

// File: rtl/synapse_weight_rf.sv
// Per-synapse signed weight register file, cleared by reset.
// Ports: clk/reset, one write port (we/waddr/wdata), one combinational read (raddr/rdata).
// Writes land at the clock edge; reads see the pre-edge value; out-of-range writes are dropped.
module synapse_weight_rf #(
  parameter int  NUM_SYNAPSES = 8,
  parameter int  WEIGHT_WIDTH = 8,
  localparam int ADDR_WIDTH   = $clog2(NUM_SYNAPSES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic signed [WEIGHT_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]          raddr,
  output logic signed [WEIGHT_WIDTH-1:0] rdata
);

  logic signed [WEIGHT_WIDTH-1:0] mem [NUM_SYNAPSES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SYNAPSES; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (32'(waddr) < NUM_SYNAPSES)) begin
      mem[waddr] <= wdata;
    end
  end

  // Guard keeps non-power-of-two sizes from reading past the array.
  assign rdata = (32'(raddr) < NUM_SYNAPSES) ? mem[raddr] : '0;

endmodule

// File: rtl/synapse_accumulator.sv
// Serial weighted spike summer feeding lif_neuron; optional tonic bias via macro SYNAPSE_BIAS_EN.
// Ports: clk, reset (async active-low), bus (slave): spike frame in, weight writes, clamped result out.
// Result N+1 edges after accept; ready only in IDLE, frames offered while busy are not taken.
module synapse_accumulator
  import snn_pkg::*;
#(
  parameter int                         NUM_SYNAPSES             = 8,
  parameter int                         WEIGHT_WIDTH             = 8,
  parameter int                         MEMBRANE_POTENTIAL_WIDTH = 8,
  parameter logic signed [WEIGHT_WIDTH-1:0] BIAS                 = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  synapse_accumulator_if.slave bus
);

  localparam int AW    = $clog2(NUM_SYNAPSES);
  localparam int ACC_W = acc_width(WEIGHT_WIDTH, NUM_SYNAPSES);
  localparam int MPW   = MEMBRANE_POTENTIAL_WIDTH;

  state_t                    state_q, state_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [NUM_SYNAPSES-1:0]   spikes_q, spikes_d;
  logic [MPW-1:0]            out_q, out_d;
  logic                      vld_q, vld_d;

  logic signed [WEIGHT_WIDTH-1:0] weight_rd;
  logic signed [ACC_W-1:0]        weight_ext;
  logic signed [ACC_W-1:0]        preload;

  synapse_weight_rf #(
    .NUM_SYNAPSES(NUM_SYNAPSES),
    .WEIGHT_WIDTH(WEIGHT_WIDTH)
  ) u_weight_rf (
    .clk   (clk),
    .reset (reset),
    .we    (bus.weight_we),
    .waddr (bus.weight_addr),
    .wdata (bus.weight_wdata),
    .raddr (idx_q),
    .rdata (weight_rd)
  );

  // Signed size cast sign-extends the weight into the accumulator width.
  assign weight_ext = ACC_W'(weight_rd);

`ifdef SYNAPSE_BIAS_EN
  assign preload = ACC_W'(BIAS);
`else
  logic unused_bias;
  assign preload     = '0;
  assign unused_bias = ^BIAS;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      spikes_q <= '0;
      out_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      spikes_q <= spikes_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    spikes_d = spikes_q;
    out_d    = '0;      // output is zero outside the strobe cycle
    vld_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.spike_in_valid) begin
          spikes_d = bus.spike_in;
          acc_d    = preload;
          idx_d    = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        // Every synapse costs one cycle, set or not, so frame timing is fixed.
        if (spikes_q[idx_q]) begin
          acc_d = acc_q + weight_ext;
        end
        idx_d = idx_q + AW'(1);
        if (32'(idx_q) == NUM_SYNAPSES - 1) begin
          idx_d   = '0;
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        out_d   = MPW'(clamp_unsigned(64'(acc_q), MPW));
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.spike_in_ready = (state_q == IDLE);
  assign bus.busy           = (state_q != IDLE);
  assign bus.synaptic_input = out_q;
  assign bus.synaptic_valid = vld_q;

endmodule

// File: tb/tb_synapse_accumulator.sv
module tb_synapse_accumulator;

  localparam int N   = 8;
  localparam int WW  = 8;
  localparam int MPW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  synapse_accumulator_if #(
    .NUM_SYNAPSES(N), .WEIGHT_WIDTH(WW), .MEMBRANE_POTENTIAL_WIDTH(MPW)
  ) bus ();

  synapse_accumulator #(
    .NUM_SYNAPSES(N), .WEIGHT_WIDTH(WW), .MEMBRANE_POTENTIAL_WIDTH(MPW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cur_pat = -1;

  typedef struct {
    int          pat;
    logic [7:0]  frame;
    int          exp;
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] weight_of(input int pat, input int i);
    case (pat)
      1:       return 8'(i + 1);
      2:       return 8'd100;
      3:       return (i < 2) ? 8'(-50) : 8'd0;
      4:       return (i % 2 == 0) ? 8'd127 : 8'h80;
      5:       return (i < 2) ? 8'd127 : ((i == 2) ? 8'd1 : 8'd0);
      default: return 8'd0;
    endcase
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic write_w(input int addr, input logic [7:0] data);
    bus.weight_we    = 1'b1;
    bus.weight_addr  = 3'(addr);
    bus.weight_wdata = data;
    @(negedge clk);
    bus.weight_we    = 1'b0;
  endtask

  task automatic load_pattern(input int pat);
    if (pat != cur_pat) begin
      for (int i = 0; i < N; i++) write_w(i, weight_of(pat, i));
      cur_pat = pat;
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.spike_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({name, "_ready_timeout"}, 32'(bus.spike_in_ready), 32'd1);
  endtask

  // Sends one frame and watches the strobe; optional weight write at cycle wr_k.
  task automatic run_frame(input logic [7:0] frame, input int exp, input string name,
                           input int wr_k, input int wr_a, input logic [7:0] wr_d);
    int first = -1;
    int val   = -1;
    int pulses = 0;
    wait_ready(name);
    bus.spike_in       = frame;
    bus.spike_in_valid = 1'b1;
    @(negedge clk);
    bus.spike_in_valid = 1'b0;
    check({name, "_busy"}, 32'(bus.busy), 32'd1);
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clk);
      if (bus.synaptic_valid) begin
        if (first < 0) begin
          first = k;
          val   = int'(bus.synaptic_input);
        end
      end
      if (bus.synaptic_valid || bus.synaptic_input != 0) pulses++;
      if (wr_k > 0 && k == wr_k) begin
        bus.weight_we    = 1'b1;
        bus.weight_addr  = 3'(wr_a);
        bus.weight_wdata = wr_d;
      end
      if (wr_k > 0 && k == wr_k + 1) bus.weight_we = 1'b0;
    end
    check({name, "_latency"}, 32'(first), 32'(N + 1));
    check({name, "_value"}, 32'(val), 32'(exp));
    check({name, "_pulse_width"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    int pk[4];
    int pv[4];

    vecs[0]  = '{0, 8'hFF,   0, "reset_weights"};
    vecs[1]  = '{1, 8'h05,   4, "basic_sum"};
    vecs[2]  = '{1, 8'hFF,  36, "ramp_all"};
    vecs[3]  = '{1, 8'h00,   0, "ramp_none"};
    vecs[4]  = '{1, 8'h80,   8, "ramp_msb"};
    vecs[5]  = '{2, 8'hFF, 255, "high_sat"};
    vecs[6]  = '{2, 8'h03, 200, "mid_200"};
    vecs[7]  = '{3, 8'h03,   0, "low_clamp"};
    vecs[8]  = '{3, 8'h02,   0, "low_single"};
    vecs[9]  = '{4, 8'h55, 255, "extreme_pos"};
    vecs[10] = '{4, 8'hFF,   0, "extreme_mix"};
    vecs[11] = '{4, 8'h05, 254, "extreme_two"};
    vecs[12] = '{5, 8'h07, 255, "exact_max"};
    vecs[13] = '{5, 8'h03, 254, "below_max"};

    bus.spike_in       = '0;
    bus.spike_in_valid = 1'b0;
    bus.weight_we      = 1'b0;
    bus.weight_addr    = '0;
    bus.weight_wdata   = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_input", 32'(bus.synaptic_input), 32'd0);
    check("rst_valid", 32'(bus.synaptic_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.spike_in_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    cur_pat = 0;

    for (int i = 0; i < 14; i++) begin
      load_pattern(vecs[i].pat);
      run_frame(vecs[i].frame, vecs[i].exp, vecs[i].name, 0, 0, 8'd0);
    end

    // Second frame offered while busy must wait for IDLE, back to back.
    load_pattern(1);
    wait_ready("bp");
    np = 0;
    bus.spike_in       = 8'h05;
    bus.spike_in_valid = 1'b1;
    @(negedge clk);
    bus.spike_in = 8'h0A;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) check("bp_ready_low", 32'(bus.spike_in_ready), 32'd0);
      if (bus.synaptic_valid && np < 4) begin
        pk[np] = k;
        pv[np] = int'(bus.synaptic_input);
        np++;
      end
      if (k == 9) check("bp_ready_idle", 32'(bus.spike_in_ready), 32'd1);
      if (k == 10) begin
        check("bp_second_accept", 32'(bus.busy), 32'd1);
        bus.spike_in_valid = 1'b0;
      end
    end
    check("bp_pulse_count", 32'(np), 32'd2);
    if (np >= 2) begin
      check("bp_first_cycle", 32'(pk[0]), 32'd9);
      check("bp_first_value", 32'(pv[0]), 32'd4);
      check("bp_second_cycle", 32'(pk[1]), 32'd19);
      check("bp_second_value", 32'(pv[1]), 32'd6);
    end

    // Write to a not-yet-scanned synapse lands in this frame.
    run_frame(8'h80, 20, "midwrite_ahead", 2, 7, 8'd20);
    run_frame(8'h80, 20, "midwrite_kept", 0, 0, 8'd0);
    // Write to an already-scanned synapse only shows up next frame.
    run_frame(8'h01, 1, "midwrite_behind", 3, 0, 8'd50);
    run_frame(8'h01, 50, "midwrite_next", 0, 0, 8'd0);

    // Reset in the middle of a scan drops the frame and clears weights.
    wait_ready("rst_mid");
    bus.spike_in       = 8'hFF;
    bus.spike_in_valid = 1'b1;
    @(negedge clk);
    bus.spike_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_input", 32'(bus.synaptic_input), 32'd0);
    check("rst_mid_valid", 32'(bus.synaptic_valid), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_ready", 32'(bus.spike_in_ready), 32'd1);
    reset = 1'b1;
    np = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.synaptic_valid || bus.synaptic_input != 0) np++;
    end
    check("rst_mid_no_pulse", 32'(np), 32'd0);
    check("rst_mid_ready_after", 32'(bus.spike_in_ready), 32'd1);
    cur_pat = 0;
    run_frame(8'hFF, 0, "rst_mid_weights", 0, 0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/synapse_accumulator.md
Name: synapse_accumulator

Overview:
- Upstream stage of lif_neuron. Converts a presynaptic spike vector into one weighted synaptic current sample that drives lif_neuron.synaptic_input.
- Holds a per-synapse signed weight register file and scans the latched spike vector serially, one synapse per clock.
- Produces a saturated unsigned sample that is non-zero for exactly one cycle per frame, so the neuron integrates each frame once.

Parameters:
- NUM_SYNAPSES, 8, number of presynaptic inputs; must be at least 2.
- WEIGHT_WIDTH, 8, signed two's-complement weight width.
- MEMBRANE_POTENTIAL_WIDTH, 8, output width; matches lif_neuron.
- BIAS, 0, signed accumulator preload value (WEIGHT_WIDTH bits); used only with SYNAPSE_BIAS_EN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- spike_in  input  NUM_SYNAPSES  presynaptic spike vector for one frame.
- spike_in_valid  input  1  spike_in is presented.
- spike_in_ready  output  1  block can accept a frame (high only in IDLE).
- weight_we  input  1  weight write strobe.
- weight_addr  input  $clog2(NUM_SYNAPSES)  weight index.
- weight_wdata  input  WEIGHT_WIDTH  signed weight value.
- synaptic_input  output  MEMBRANE_POTENTIAL_WIDTH  clamped weighted sum; 0 when synaptic_valid is low.
- synaptic_valid  output  1  one-cycle result strobe.
- busy  output  1  high in ACCUM and OUTPUT.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, idx=0, acc=0, latched vector=0, all weights=0.
  - synaptic_input=0, synaptic_valid=0, busy=0, spike_in_ready=1.
- Accumulator: signed, WEIGHT_WIDTH+$clog2(NUM_SYNAPSES)+1 bits. It cannot overflow internally.
- FSM states:
  - IDLE:
    - spike_in_ready=1.
    - On valid&ready at a clock edge: latch spike_in, acc<=0 (or BIAS), idx<=0, go to ACCUM.
  - ACCUM:
    - Each edge: if latched[idx]=1, acc<=acc+sext(weight[idx]); idx<=idx+1.
    - After the edge that processes idx=NUM_SYNAPSES-1, go to OUTPUT.
    - Always takes exactly NUM_SYNAPSES cycles; zero bits are not skipped.
  - OUTPUT:
    - On the next edge: synaptic_input<=clamp(acc), synaptic_valid<=1, go to IDLE.
- Clamp: acc<0 gives 0; acc>2^MEMBRANE_POTENTIAL_WIDTH-1 gives 2^MEMBRANE_POTENTIAL_WIDTH-1; otherwise acc[MEMBRANE_POTENTIAL_WIDTH-1:0].
- Result strobe: synaptic_valid and a non-zero synaptic_input last one cycle. On the following edge both return to 0.
- Latency: the result is registered at the (NUM_SYNAPSES+1)th rising edge after the accepting edge. Minimum frame period is NUM_SYNAPSES+2 cycles.
- spike_in_valid while busy is ignored; no frame is queued. The source must hold valid until it sees ready.
- Weight writes:
  - Accepted in any state, taking effect at the edge.
  - Weight reads are combinational from the register file. A write to the address being read in the same cycle uses the old value (read-before-write).
  - A write to an address already scanned affects only later frames.
- weight_addr >= NUM_SYNAPSES with weight_we=1: the write is ignored.
- Reset asserted mid-ACCUM or mid-OUTPUT: the frame is discarded, no valid pulse is produced, and all state returns to reset values, including weights.

Optional Feature:
- Macro: SYNAPSE_BIAS_EN.
- Defined: acc is preloaded with sext(BIAS) on frame accept, giving the neuron a constant tonic drive. An all-zero spike vector then yields clamp(BIAS).
- Undefined: acc is preloaded with 0, the BIAS parameter is unused, and an all-zero vector yields 0.

Decomposition:
- snn_pkg holds:
  - the state enum (IDLE, ACCUM, OUTPUT);
  - the accumulator-width localparam function;
  - a clamp_unsigned function shared with future neuron stages.
- One sub-module: synapse_weight_rf. NUM_SYNAPSES x WEIGHT_WIDTH register file with async clear, one write port and one combinational read port.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> synaptic_input=0, synaptic_valid=0, busy=0, spike_in_ready=1. All weights read 0, so the frame 8'hFF yields 0.
- Basic sum: write w[i]=i+1 (i=0..7), frame 8'b0000_0101 -> synaptic_input=4, valid for exactly 1 cycle at the 9th edge after accept, 0 before and after.
- High saturation: all weights=100, frame 8'hFF -> acc=800, synaptic_input=255.
- Low clamp: w[0]=w[1]=-50, frame 8'h03 -> acc=-100, synaptic_input=0 with synaptic_valid=1.
- Backpressure and mid-frame write:
  - Setup: w[i]=i+1 as in Basic sum.
  - Assert a second valid frame while busy -> ready=0, no effect; the frame is accepted after the return to IDLE.
  - Write w[7]=20 during scan idx=2 of frame 8'h80 -> result is 20.
- Reset mid-frame: deassert-then-assert reset at ACCUM idx=3 -> no valid pulse, outputs 0, ready=1, weights cleared.
